ram_block_io: RTL and testbench
===============================

// Module: ram_block_io
// PURPOSE
//  Bus master for single_port_ram (8-bit addr/data, 1-cycle registered read).
//  - Reads a BYTES-byte block from the RAM into one wide word.
//  - Writes one wide word back as BYTES consecutive bytes.
//  - Links the cipher core (plaintext/key/ciphertext blocks) to its RAMs.
//  - One instance per RAM; the core never drives RAM ports directly.
// PARAMETERS
//  BYTES  8  block length in bytes (legal 1..16; 8 = data block, 16 = key)
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  rst_n      in   1        asynchronous, active-low reset
//  start_rd   in   1        request block read (sampled in IDLE only)
//  start_wr   in   1        request block write (sampled in IDLE only)
//  base_addr  in   8        first RAM address of block (sampled with start)
//  wr_block   in   8*BYTES  write data (sampled with start_wr)
//  rd_block   out  8*BYTES  last block read
//  busy       out  1        transfer in progress
//  done       out  1        1-cycle pulse: transfer complete
//  verify_err out  1        write-back mismatch flag (see CONFIGURATION)
//  ram_we     out  1        RAM write enable
//  ram_addr   out  8        RAM address
//  ram_din    out  8        RAM write data
//  ram_dout   in   8        RAM read data (valid 1 edge after ram_addr)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - Outputs to 0: rd_block, busy, done, verify_err, ram_we, ram_addr, ram_din.
//  - FSM to IDLE; RAM write stops immediately.
//  - Reset mid-transfer aborts it; no done; rd_block cleared.
//  All outputs registered. FSM: IDLE, RD, WR (+ VFY with macro).
//  Byte order: byte at base_addr = MSB, rd_block/wr_block[8*BYTES-1 -: 8].
//  - RAM bytes 11 22 .. 88 <-> 64'h1122334455667788.
//  Addressing: base_addr+i mod 256; wraps 0xFF->0x00, no error.
//  Edge 0 = edge that samples start in IDLE.
//  RD:
//  - Edge k (0..BYTES-1): ram_addr <= base+k.
//  - Edge k+2: capture ram_dout as byte k.
//  - Last capture at edge BYTES+1; done=1, busy=0 from that edge.
//  - BYTES=8: done at edge 9.
//  - rd_block updates only at done; holds between reads.
//  - rd_block is never partially visible.
//  WR:
//  - Edge k (0..BYTES-1): ram_we=1, ram_addr=base+k, ram_din=byte k.
//  - Edge BYTES: ram_we=0, done=1, busy=0 (BYTES=8: edge 8).
//  - wr_block is latched at edge 0; later changes are ignored.
//  busy=1 from edge 0 until done rises.
//  - Starts while busy are ignored (not queued).
//  - A start in the done cycle is accepted.
//  Simultaneous start_rd & start_wr in IDLE: read wins; write dropped.
//  ram_we is never 1 outside WR. ram_din is 0 when ram_we=0.
// CONFIGURATION
//  Macro RAM_BLOCK_IO_VERIFY_EN.
//  Defined:
//  - After WR, go to VFY; read the block back with the RD timing.
//  - done rises at edge BYTES + BYTES + 2.
//  - verify_err=1 if any byte differs from the latched wr_block.
//  - verify_err holds until next start.
//  - VFY does not change rd_block.
//  Undefined:
//  - No VFY state. verify_err is tied 0.
//  - WR timing is as in BEHAVIOUR.
// TESTING
//  T1 reset: rst_n=0 mid-WR at edge 3 -> ram_we=0 async; all outputs 0;
//     IDLE after release; no done.
//  T2 read, INIT_TYPE=1 RAM: start_rd, base=0x00
//     -> done at edge 9, rd_block=64'h1122334455667788.
//  T3 write/read: start_wr base=0x10, wr_block=64'hc3b90eb52256fe61
//     -> done edge 8; then start_rd base=0x10 -> same value.
//  T4 wrap: write 64'h0102030405060708 at base=0xFC
//     -> RAM[FC..FF]=01..04, RAM[00..03]=05..08; read back matches.
//  T5 contention: start_rd=start_wr=1 -> read only, ram_we never 1.
//     start_rd at edge 4 while busy -> ignored, one done only.
//  T6 macro on: write 64'hAA..AA, RAM models corrupted byte 3
//     -> verify_err=1 at done (edge 18). Clean RAM -> verify_err=0.

Source files
------------

// File: rtl/ram_block_io.sv
// Block transfer master for an 8-bit single-port RAM with a registered read.
// Optional write-back verification pass is enabled by RAM_BLOCK_IO_VERIFY_EN.
module ram_block_io #(
    parameter int BYTES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_rd,
    input  logic               start_wr,
    input  logic [7:0]         base_addr,
    input  logic [8*BYTES-1:0] wr_block,
    output logic [8*BYTES-1:0] rd_block,
    output logic               busy,
    output logic               done,
    output logic               verify_err,
    output logic               ram_we,
    output logic [7:0]         ram_addr,
    output logic [7:0]         ram_din,
    input  logic [7:0]         ram_dout
);
    localparam int W  = 8 * BYTES;
    localparam int CW = $clog2(BYTES + 3);

    // state | meaning
    // IDLE  | waiting for start_rd / start_wr
    // RD    | issuing addresses and capturing bytes into rd_block
    // WR    | writing latched block, one byte per cycle
    // VFY   | reading block back and comparing with latched data
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_VFY  = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [7:0]    base_q;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  shreg;
    logic [W-1:0]  din_ext;
    logic [W-1:0]  captured;

    function automatic logic [W-1:0] rotl8(input logic [W-1:0] x);
        return (x << 8) | (x >> (W - 8));
    endfunction

    assign din_ext  = W'(ram_dout);
    assign captured = (shreg << 8) | din_ext;

    // cnt counts edges remaining in the current phase; terminal count is 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            base_q     <= '0;
            wr_data    <= '0;
            shreg      <= '0;
            rd_block   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            verify_err <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_din    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_rd) begin
                        state      <= S_RD;
                        busy       <= 1'b1;
                        cnt        <= CW'(BYTES + 1);
                        ram_addr   <= base_addr;
                        verify_err <= 1'b0;
                    end else if (start_wr) begin
                        state      <= S_WR;
                        busy       <= 1'b1;
                        cnt        <= CW'(BYTES);
                        ram_we     <= 1'b1;
                        ram_addr   <= base_addr;
                        ram_din    <= wr_block[W-1 -: 8];
                        wr_data    <= rotl8(wr_block);
                        base_q     <= base_addr;
                        verify_err <= 1'b0;
                    end
                end
                S_RD, S_VFY: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(BYTES + 2))
                        ram_addr <= base_q;
                    else if (cnt > CW'(2))
                        ram_addr <= ram_addr + 8'd1;
                    if (cnt <= CW'(BYTES))
                        shreg <= captured;
                    if (cnt == CW'(1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (state == S_RD)
                            rd_block <= captured;
`ifdef RAM_BLOCK_IO_VERIFY_EN
                        else
                            verify_err <= (captured != wr_data);
`endif
                    end
                end
                S_WR: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        ram_we  <= 1'b0;
                        ram_din <= '0;
`ifdef RAM_BLOCK_IO_VERIFY_EN
                        // one idle edge lets the final write land before read-back starts
                        state   <= S_VFY;
                        cnt     <= CW'(BYTES + 2);
`else
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
`endif
                    end else begin
                        ram_addr <= ram_addr + 8'd1;
                        ram_din  <= wr_data[W-1 -: 8];
                        wr_data  <= rotl8(wr_data);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_block_io.sv
// Directed + random bench for ram_block_io against an array-based RAM reference.
module tb_ram_block_io;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_rd, start_wr;
    logic [7:0]  base_addr;
    logic [63:0] wr_block;
    logic [63:0] rd_block;
    logic        busy, done, verify_err, ram_we;
    logic [7:0]  ram_addr, ram_din, ram_dout;

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;
    bit reading = 1'b0;
    bit load_en = 1'b1;
    bit corrupt_en = 1'b0;
    logic [7:0] corrupt_addr = 8'h00;

    logic [7:0] mem [256];
    logic [7:0] init_val [256];
    logic [7:0] ref_mem [256];

`ifdef RAM_BLOCK_IO_VERIFY_EN
    localparam int WR_LAT = 18;
`else
    localparam int WR_LAT = 8;
`endif

    ram_block_io #(.BYTES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start_rd(start_rd), .start_wr(start_wr),
        .base_addr(base_addr), .wr_block(wr_block), .rd_block(rd_block),
        .busy(busy), .done(done), .verify_err(verify_err), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val[i];
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr] ^ ((corrupt_en && ram_addr == corrupt_addr) ? 8'hFF : 8'h00);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (!ram_we && ram_din !== 8'h00) viol++;
            if (reading && ram_we) viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_rd(input logic [7:0] b);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a = b + 8'(i);
            r = {r[55:0], ref_mem[a]};
        end
        return r;
    endfunction

    task automatic ref_write(input logic [7:0] b, input logic [63:0] d, input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            logic [7:0] a = b + 8'(i);
            ref_mem[a] = d[63-8*i -: 8];
        end
    endtask

    // mode: 0 read, 1 write, 2 both starts asserted; returns edges from start to done
    task automatic run_op(input int mode, input logic [7:0] base, input logic [63:0] data,
                          output int lat);
        start_rd  = (mode != 1);
        start_wr  = (mode != 0);
        base_addr = base;
        wr_block  = data;
        reading   = (mode != 1);
        @(posedge clk); #1;
        start_rd = 1'b0;
        start_wr = 1'b0;
        wr_block = ~data;
        base_addr = ~base;
        check("busy_after_start", busy, 1);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
        check("busy_at_done", busy, 0);
        reading = 1'b0;
    endtask

    initial begin
        int lat;
        int dones;
        int bad;
        logic [63:0] d;
        logic [7:0]  b;
        logic [63:0] last_rd;

        rst_n = 1'b0; start_rd = 1'b0; start_wr = 1'b0;
        base_addr = '0; wr_block = '0;
        for (int i = 0; i < 256; i++) init_val[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) init_val[i] = 8'((i + 1) * 8'h11);
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val[i];

        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_block", rd_block, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_verify_err", verify_err, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_din", ram_din, 0);
        load_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // plain read of initialised RAM
        run_op(0, 8'h00, 64'h0, lat);
        check("t2_lat", lat, 9);
        check("t2_data", rd_block, 64'h1122334455667788);
        @(posedge clk); #1;
        check("t2_done_pulse", done, 0);
        check("t2_hold", rd_block, 64'h1122334455667788);

        // write then read back
        run_op(1, 8'h10, 64'hc3b90eb52256fe61, lat);
        ref_write(8'h10, 64'hc3b90eb52256fe61, 8);
        check("t3_wr_lat", lat, WR_LAT);
        check("t3_verify", verify_err, 0);
        run_op(0, 8'h10, 64'h0, lat);
        check("t3_rd_lat", lat, 9);
        check("t3_data", rd_block, 64'hc3b90eb52256fe61);

        // address wrap
        run_op(1, 8'hFC, 64'h0102030405060708, lat);
        ref_write(8'hFC, 64'h0102030405060708, 8);
        check("t4_wr_lat", lat, WR_LAT);
        check("t4_mem_fc", mem[8'hFC], 8'h01);
        check("t4_mem_ff", mem[8'hFF], 8'h04);
        check("t4_mem_00", mem[8'h00], 8'h05);
        check("t4_mem_03", mem[8'h03], 8'h08);
        run_op(0, 8'hFC, 64'h0, lat);
        check("t4_data", rd_block, 64'h0102030405060708);

        // reset in the middle of a write
        d = 64'h8877665544332211;
        start_wr = 1'b1; base_addr = 8'h40; wr_block = d;
        @(posedge clk); #1;
        start_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t1_we_before", ram_we, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_we_async", ram_we, 0);
        check("t1_busy", busy, 0);
        check("t1_rd_block", rd_block, 0);
        check("t1_addr", ram_addr, 0);
        check("t1_din", ram_din, 0);
        ref_write(8'h40, d, 3);
        dones = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("t1_no_done", dones, 0);
        check("t1_idle_busy", busy, 0);
        run_op(0, 8'h40, 64'h0, lat);
        check("t1_rd_lat", lat, 9);
        check("t1_partial", rd_block, exp_rd(8'h40));

        // simultaneous starts: read wins
        bad = viol;
        run_op(2, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF, lat);
        check("t5_lat", lat, 9);
        check("t5_data", rd_block, exp_rd(8'h10));
        check("t5_no_write", viol - bad, 0);

        // start while busy is dropped
        start_rd = 1'b1; base_addr = 8'h00;
        @(posedge clk); #1;
        start_rd = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start_rd = 1'b1; base_addr = 8'h40;
        @(posedge clk); #1;
        start_rd = 1'b0;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("t5_one_done", dones, 1);
        check("t5_first_data", rd_block, exp_rd(8'h00));

        // random writes, each immediately followed by a read started in the done cycle
        for (int it = 0; it < 8; it++) begin
            b = 8'($urandom);
            d = {$urandom, $urandom};
            run_op(1, b, d, lat);
            ref_write(b, d, 8);
            check("rnd_wr_lat", lat, WR_LAT);
            check("rnd_verify", verify_err, 0);
            b = 8'($urandom_range(0, 255));
            run_op(0, b, 64'h0, lat);
            check("rnd_rd_lat", lat, 9);
            check("rnd_rd_data", rd_block, exp_rd(b));
        end
        last_rd = exp_rd(b);

`ifdef RAM_BLOCK_IO_VERIFY_EN
        corrupt_en = 1'b1; corrupt_addr = 8'h23;
        run_op(1, 8'h20, 64'hAAAA_AAAA_AAAA_AAAA, lat);
        ref_write(8'h20, 64'hAAAA_AAAA_AAAA_AAAA, 8);
        check("t6_lat", lat, 18);
        check("t6_err", verify_err, 1);
        check("t6_rd_untouched", rd_block, last_rd);
        @(posedge clk); #1;
        check("t6_err_hold", verify_err, 1);
        corrupt_en = 1'b0;
        run_op(1, 8'h20, 64'hAAAA_AAAA_AAAA_AAAA, lat);
        check("t6_clean", verify_err, 0);
`else
        check("t6_err_tied", verify_err, 0);
`endif

        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("final_mem", bad, 0);
        check("we_din_rules", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
